// File: rtl/xs3_bcd_seq_ctrl_pkg.sv
// Shared types and constants for the excess-3 to BCD sequencing controller.
package xs3_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] XS3_BIAS       = 4'd3;
  localparam logic [3:0] XS3_MIN        = 4'd3;
  localparam logic [3:0] XS3_MAX        = 4'd12;
  localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

  // Digit index width; a single-digit word still needs a 1-bit counter.
  function automatic int unsigned idxWidth(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/xs3_bcd_seq_ctrl_if.sv
// Producer/consumer handshake bundle for xs3_bcd_seq_ctrl.
interface xs3_bcd_seq_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_xs3;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [DIGITS-1:0]     err_mask;
  logic                  out_err;

  modport master (
    output in_valid, in_xs3, out_ready,
    input  in_ready, out_valid, out_bcd, err_mask, out_err
  );

  modport slave (
    input  in_valid, in_xs3, out_ready,
    output in_ready, out_valid, out_bcd, err_mask, out_err
  );
endinterface

// File: rtl/xs3_bcd_seq_ctrl_conv.sv
// Combinational single-digit excess-3 to BCD converter with invalid-code flag.
module xs3_digit_to_bcd
  import xs3_bcd_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    invalid = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
    bcd     = invalid ? BCD_ERR_NIBBLE : (xs3 - XS3_BIAS);
  end

endmodule

// File: rtl/xs3_bcd_seq_ctrl.sv
// Converts a packed excess-3 word to packed BCD one digit per clock through a
// single shared digit converter, with valid/ready handshakes on both sides.
module xs3_bcd_seq_ctrl
  import xs3_bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input logic           clk,
  input logic           rst_n,
  xs3_bcd_seq_ctrl_if.slave bus
);

  localparam int unsigned IDXW = idxWidth(DIGITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CONV = CONV;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]          state;
  logic [IDXW-1:0]     idx;
  logic [4*DIGITS-1:0] capReg;
  logic [4*DIGITS-1:0] outBcd;
  logic [DIGITS-1:0]   errMask;

  logic [3:0] convIn;
  logic [3:0] convBcd;
  logic       convBad;

  assign convIn = capReg[4*idx +: 4];

  xs3_digit_to_bcd uConv (
    .xs3     (convIn),
    .bcd     (convBcd),
    .invalid (convBad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      capReg  <= '0;
      outBcd  <= '0;
      errMask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // in_ready is high whenever IDLE is reached out of reset
          if (bus.in_valid) begin
            capReg  <= bus.in_xs3;
            outBcd  <= '0;
            errMask <= '0;
            idx     <= '0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          outBcd[4*idx +: 4] <= convBcd;
          errMask[idx]       <= convBad;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_bcd   = outBcd;
  assign bus.err_mask  = errMask;
  assign bus.out_err   = |errMask;

endmodule

// File: doc/xs3_bcd_seq_ctrl.md
# xs3_bcd_seq_ctrl

Sequencing controller that converts a multi-digit packed excess-3 word into packed BCD by time-sharing a single 4-bit excess-3-to-BCD digit converter, one digit per clock. It sits between an excess-3 producer and a BCD consumer, with valid/ready handshakes on both sides. It also flags out-of-range excess-3 codes per digit.

## Interface
- DIGITS, 4, number of 4-bit digits per word (≥1); digit 0 = bits [3:0].
- clk  in  1  system clock; one clock domain; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has a word on in_xs3.
- in_ready  out  1  controller accepts a word this cycle.
- in_xs3  in  4*DIGITS  packed excess-3 digits.
- out_valid  out  1  result word available.
- out_ready  in  1  consumer takes result this cycle.
- out_bcd  out  4*DIGITS  packed BCD result.
- err_mask  out  DIGITS  bit i set = digit i was an invalid excess-3 code.
- out_err  out  1  OR-reduction of err_mask.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture in_xs3 into the input register, clear the result register and err_mask, set idx=0, go to CONV.
- CONV: in_ready=0. Each cycle drives digit idx of the captured word into the converter and writes the result nibble to out_bcd[4*idx+:4] and the error flag to err_mask[idx]. idx increments; when idx==DIGITS-1 is written, go to DONE.
- DONE: out_valid=1. out_bcd, err_mask and out_err stay stable until out_ready=1, then go to IDLE.
- Digit conversion: valid code E in 3..12 gives BCD = E-3 (4-bit). Invalid code E in {0,1,2,13,14,15} gives nibble 4'hF and sets the error flag.
- in_valid is ignored outside IDLE; the input word is not re-sampled during CONV.
- Reset: synchronous on rising edge with rst_n=0. Forces state=IDLE, idx=0, out_bcd=0, err_mask=0, out_valid=0. in_ready=0 while rst_n=0 and 1 afterwards. A reset mid-CONV or in DONE discards the partial or pending result; no output handshake occurs.

## Timing
- Acceptance edge T (IDLE, in_valid&&in_ready). Digits are written at edges T+1..T+DIGITS. out_valid is high starting in the cycle after edge T+DIGITS.
- Latency: DIGITS cycles from acceptance to out_valid. With out_ready held high, DONE lasts 1 cycle and IDLE 1 cycle, so minimum throughput is one word per DIGITS+2 cycles.
- Backpressure: with out_ready=0, DONE holds indefinitely and outputs are unchanged.
- in_ready and out_valid are decoded from registered state only (no combinational path from in_valid/out_ready).
- idx width is clog2(DIGITS), minimum 1. DIGITS=1 goes IDLE→CONV→DONE with a single conversion cycle.

## Structure
- Package xs3_bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE);
  - constants XS3_BIAS=3, XS3_MIN=3, XS3_MAX=12, BCD_ERR_NIBBLE=4'hF.
- Sub-module xs3_digit_to_bcd: combinational, 4-bit excess-3 in, 4-bit BCD out plus invalid flag. It is the single shared converter instance.
- The controller holds the FSM, idx counter, input capture register and result/err registers.

## Test plan
- Nominal, DIGITS=4, out_ready=1:
  - in_xs3=16'h4C83 → out_bcd=16'h1950, err_mask=4'b0000, out_err=0.
  - out_valid is asserted exactly 4 cycles after acceptance.
- Invalid codes: in_xs3=16'h3F03 → out_bcd=16'h0FF0, err_mask=4'b0110, out_err=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → out_bcd stable, in_ready=0 throughout.
  - Drive a new in_valid during this time → it is not accepted until DONE→IDLE.
- Back-to-back:
  - in_valid held high with words 16'h3333 then 16'hCCCC → results 16'h0000 then 16'h9999.
  - Second acceptance occurs DIGITS+2 cycles after the first.
- Reset mid-operation:
  - rst_n=0 at conversion cycle 2 → next cycle out_valid=0, out_bcd=0, err_mask=0.
  - No output handshake for the aborted word.
  - Post-reset word 16'h5678 → 16'h2345.
- Exhaustive digit sweep, DIGITS=1: E=0..15 → BCD E-3 for 3..12, otherwise 4'hF with err_mask=1.
